// File: rtl/puzzle_move_ctrl.sv
// ---------------------------------------------------------------------------
// puzzle_move_ctrl
// Applies one slide move to a 3x3 sliding-puzzle board held in a register
// file. The blank cell moves in the direction given by dir. The resulting
// board is written back to the register file, and it is compared with a
// goal board.
//
// Board word: [39:36] blank cell index (0..8). Cell k holds its tile at
// [35-4k:32-4k]. Cells are numbered row-major.
//
// Command flow: IDLE -> FETCH -> EVAL -> WRITE -> DONE -> IDLE.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, sampled only in IDLE
//   dir                 00 up, 01 down, 10 left, 11 right
//   src_idx/dst_idx     source / destination register index
//   goal_idx            goal board register index
//   rf_src0/rf_src1     read addresses (board / goal)
//   rf_data0/rf_data1   combinational read data
//   rf_dst/rf_we/rf_data write port, active only in WRITE for a legal move
//   busy, done          status; done is a one-cycle pulse
//   legal, solved       result flags, held from done until the next command
//                       overwrites them
//   move_cnt            saturating legal-move counter
//
// Optional feature: define PUZZLE_MOVE_COUNT_EN to add move_cnt.
// ---------------------------------------------------------------------------
module puzzle_move_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  dir,
    input  logic [3:0]  src_idx,
    input  logic [3:0]  dst_idx,
    input  logic [3:0]  goal_idx,
    output logic [3:0]  rf_src0,
    output logic [3:0]  rf_src1,
    input  logic [39:0] rf_data0,
    input  logic [39:0] rf_data1,
    output logic [3:0]  rf_dst,
    output logic        rf_we,
    output logic [39:0] rf_data,
    output logic        busy,
    output logic        done,
    output logic        legal,
    output logic        solved
`ifdef PUZZLE_MOVE_COUNT_EN
    ,
    output logic [CNT_W-1:0] move_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  dir_r;
    logic [39:0] board_r, goal_r;
    logic        legal_r, solved_r;

    // move evaluation (combinational, registered at the end of EVAL)
    logic [3:0]  p, q;
    logic        lgl;
    logic [3:0]  tile_p, tile_q;
    logic [39:0] nb;

    always_comb begin
        p      = board_r[39:36];
        lgl    = 1'b0;
        q      = p;
        tile_p = '0;
        tile_q = '0;
        nb     = board_r;
        case (dir_r)
            2'b00: begin lgl = (p >= 4'd3) && (p <= 4'd8); q = p - 4'd3; end
            2'b01: begin lgl = (p <= 4'd5);                q = p + 4'd3; end
            2'b10: begin lgl = (p <= 4'd8) && (p != 4'd0) && (p != 4'd3) && (p != 4'd6);
                         q = p - 4'd1; end
            default: begin lgl = (p <= 4'd8) && (p != 4'd2) && (p != 4'd5) && (p != 4'd8);
                         q = p + 4'd1; end
        endcase
        for (int k = 0; k < 9; k++) begin
            if (p == k[3:0]) tile_p = board_r[35-4*k -: 4];
            if (q == k[3:0]) tile_q = board_r[35-4*k -: 4];
        end
        if (lgl) begin
            for (int k = 0; k < 9; k++) begin
                if (p == k[3:0]) nb[35-4*k -: 4] = tile_q;
                if (q == k[3:0]) nb[35-4*k -: 4] = tile_p;
            end
            nb[39:36] = q;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = EVAL;
            EVAL:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dir_r    <= '0;
            rf_src0  <= '0;
            rf_src1  <= '0;
            rf_dst   <= '0;
            rf_data  <= '0;
            board_r  <= '0;
            goal_r   <= '0;
            legal_r  <= 1'b0;
            solved_r <= 1'b0;
            legal    <= 1'b0;
            solved   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    dir_r   <= dir;
                    rf_src0 <= src_idx;
                    rf_src1 <= goal_idx;
                    rf_dst  <= dst_idx;
                end
                FETCH: begin
                    board_r <= rf_data0;
                    goal_r  <= rf_data1;
                end
                EVAL: begin
                    // nb is the unmodified source when the move is illegal.
                    rf_data  <= nb;
                    legal_r  <= lgl;
                    solved_r <= (nb == goal_r);
                end
                WRITE: begin
                    legal  <= legal_r;
                    solved <= solved_r;
                end
                default: ;
            endcase
        end
    end

    assign rf_we = (state == WRITE) && legal_r;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

`ifdef PUZZLE_MOVE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            move_cnt <= '0;
        else if (rf_we && (move_cnt != {CNT_W{1'b1}}))
            move_cnt <= move_cnt + 1'b1;
    end
`else
    // CNT_W only sizes the counter. This empty branch keeps the parameter referenced.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule
